// File: rtl/sysid_checker_pkg.sv
// Shared constants for the system-ID checker: state encoding, word addresses
// and the wait-counter width.
package sysid_checker_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RD_ID = 2'd1,
    S_RD_TS = 2'd2,
    S_FIN   = 2'd3
  } state_e;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;
  localparam int   CNT_W   = 16;

endpackage

// File: rtl/sysid_checker_timer.sv
// Wait-request watchdog: counts stalled cycles of the current read and flags
// the cycle in which the count would reach the limit.
module sysid_checker_timer
  import sysid_checker_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // Fires on the stalled cycle whose count hits the limit, so the FSM aborts on that edge.
  assign expired = enable && !clear && ((cnt_q + CNT_W'(1)) == limit);

endmodule

// File: rtl/sysid_checker.sv
// Reads the system ID (word 0) and build timestamp (word 1) over Avalon-MM and
// compares them with the expected values. Define SYSID_CHECKER_TIMEOUT_EN to
// abort reads whose wait-request stall reaches TIMEOUT_CYCLES.
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd991051294,
  parameter logic [31:0] EXPECTED_TS    = 32'd1260225362,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        timeout
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("sysid_checker: TIMEOUT_CYCLES out of range 1..65535");
  end

  state_e      state_q, state_d;
  logic        avm_read_q, avm_read_d;
  logic        avm_address_q, avm_address_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  logic        tmr_expired;

`ifdef SYSID_CHECKER_TIMEOUT_EN
  logic tmr_clear, tmr_enable;

  // Restart the count whenever a new read is issued.
  assign tmr_clear  = (state_q == S_IDLE  && start) ||
                      (state_q == S_RD_ID && !avm_waitrequest);
  assign tmr_enable = (state_q == S_RD_ID || state_q == S_RD_TS) && avm_waitrequest;

  sysid_checker_timer u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .limit   (CNT_W'(TIMEOUT_CYCLES)),
    .expired (tmr_expired)
  );
`else
  assign tmr_expired = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    avm_read_d    = avm_read_q;
    avm_address_d = avm_address_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    id_ok_d       = id_ok_q;
    ts_ok_d       = ts_ok_q;
    timeout_d     = timeout_q;
    id_value_d    = id_value_q;
    ts_value_d    = ts_value_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_RD_ID;
          avm_read_d    = 1'b1;
          avm_address_d = ADDR_ID;
          busy_d        = 1'b1;
          id_ok_d       = 1'b0;
          ts_ok_d       = 1'b0;
          timeout_d     = 1'b0;
        end
      end
      S_RD_ID, S_RD_TS: begin
        if (!avm_waitrequest) begin
          if (state_q == S_RD_ID) begin
            id_value_d    = avm_readdata;
            state_d       = S_RD_TS;
            avm_address_d = ADDR_TS;
          end else begin
            // Compare against the live read data; ts_value_q updates on this same edge.
            ts_value_d    = avm_readdata;
            state_d       = S_FIN;
            avm_read_d    = 1'b0;
            avm_address_d = ADDR_ID;
            busy_d        = 1'b0;
            done_d        = 1'b1;
            id_ok_d       = (id_value_q == EXPECTED_ID);
            ts_ok_d       = (avm_readdata == EXPECTED_TS);
          end
        end else if (tmr_expired) begin
          state_d       = S_FIN;
          avm_read_d    = 1'b0;
          avm_address_d = ADDR_ID;
          busy_d        = 1'b0;
          done_d        = 1'b1;
          id_ok_d       = 1'b0;
          ts_ok_d       = 1'b0;
          timeout_d     = 1'b1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      avm_read_q    <= 1'b0;
      avm_address_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      id_ok_q       <= 1'b0;
      ts_ok_q       <= 1'b0;
      timeout_q     <= 1'b0;
      id_value_q    <= '0;
      ts_value_q    <= '0;
    end else begin
      state_q       <= state_d;
      avm_read_q    <= avm_read_d;
      avm_address_q <= avm_address_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      id_ok_q       <= id_ok_d;
      ts_ok_q       <= ts_ok_d;
      timeout_q     <= timeout_d;
      id_value_q    <= id_value_d;
      ts_value_q    <= ts_value_d;
    end
  end

  assign avm_read    = avm_read_q;
  assign avm_address = avm_address_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: table of read scenarios plus hand-written
// sequences for back-to-back starts, mid-read reset and (when enabled) timeout.
module tb_sysid_checker;

  localparam logic [31:0] EID = 32'd991051294;
  localparam logic [31:0] ETS = 32'd1260225362;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_address, avm_read, avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  logic [31:0] rd_id = '0, rd_ts = '0;
  int          wait_n = 0;
  int          wcnt = 0;
  logic        stuck = 1'b0;
  int          n_chk = 0, n_pass = 0;

  typedef struct {
    logic [31:0] id_d;
    logic [31:0] ts_d;
    int          waits;
    int          lat;
    logic        exp_id_ok;
    logic        exp_ts_ok;
  } vec_t;

  vec_t vecs[5];

  sysid_checker #(
    .EXPECTED_ID    (EID),
    .EXPECTED_TS    (ETS),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .done            (done),
    .id_ok           (id_ok),
    .ts_ok           (ts_ok),
    .id_value        (id_value),
    .ts_value        (ts_value),
    .timeout         (timeout)
  );

  always #5 clk = ~clk;

  // Slave model: wait_n stall cycles per read, or stalled forever when stuck.
  assign avm_readdata    = avm_address ? rd_ts : rd_id;
  assign avm_waitrequest = avm_read && (stuck || (wcnt < wait_n));

  always @(posedge clk) begin
    if (avm_read && avm_waitrequest) wcnt <= wcnt + 1;
    else                             wcnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Address and read strobe must not move while the slave is stalling.
  logic mon_en = 1'b0, p_wr = 1'b0, p_rd = 1'b0, p_addr = 1'b0;
  always @(negedge clk) begin
    if (mon_en && p_wr && p_rd) begin
      chk("hold_read", {31'd0, avm_read}, 32'd1);
      chk("hold_addr", {31'd0, avm_address}, {31'd0, p_addr});
    end
    p_wr   <= avm_waitrequest;
    p_rd   <= avm_read;
    p_addr <= avm_address;
  end

  task automatic check_all_zero(input string name);
    chk(name, {25'd0, avm_read, avm_address, busy, done, id_ok, ts_ok, timeout}, 32'd0);
    chk({name, "_idv"}, id_value, 32'd0);
    chk({name, "_tsv"}, ts_value, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int k;
    rd_id  = v.id_d;
    rd_ts  = v.ts_d;
    wait_n = v.waits;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 1;
    chk({tag, "_busy_on"}, {31'd0, busy}, 32'd1);
    chk({tag, "_rd_id"}, {30'd0, avm_read, avm_address}, 32'd2);
    while (!done && k < 60) begin
      @(posedge clk); #1 k++;
    end
    chk({tag, "_latency"}, k, v.lat);
    chk({tag, "_id_ok"}, {31'd0, id_ok}, {31'd0, v.exp_id_ok});
    chk({tag, "_ts_ok"}, {31'd0, ts_ok}, {31'd0, v.exp_ts_ok});
    chk({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    chk({tag, "_id_value"}, id_value, v.id_d);
    chk({tag, "_ts_value"}, ts_value, v.ts_d);
    chk({tag, "_fin_idle"}, {30'd0, busy, avm_read}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int k, dones;
    vecs[0] = '{EID,           ETS,                  0, 3,  1'b1, 1'b1};
    vecs[1] = '{EID,           32'h0000_0000,        0, 3,  1'b1, 1'b0};
    vecs[2] = '{32'hDEAD_BEEF, ETS,                  0, 3,  1'b0, 1'b1};
    vecs[3] = '{EID,           ETS,                  4, 11, 1'b1, 1'b1};
    vecs[4] = '{EID ^ 32'd1,   ETS ^ 32'h8000_0000,  1, 5,  1'b0, 1'b0};

    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // start held high: FIN, one idle cycle, then the next RD_ID
    rd_id = EID; rd_ts = ETS; wait_n = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 chk("rep_e1_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1 chk("rep_e2_rd_ts", {30'd0, avm_read, avm_address}, 32'd3);
    @(posedge clk); #1 chk("rep_e3_done", {30'd0, done, avm_read}, 32'd2);
    @(posedge clk); #1 chk("rep_e4_idle", {29'd0, done, avm_read, busy}, 32'd0);
    @(posedge clk); #1 chk("rep_e5_rd_id", {29'd0, avm_read, avm_address, busy}, 32'd5);
    @(posedge clk); #1;
    @(posedge clk); #1 chk("rep_e7_done", {30'd0, done, ts_ok}, 32'd3);
    start = 1'b0;
    @(posedge clk); #1;

    // reset asserted while the timestamp read is stalled
    wait_n = 3;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    while (!(avm_read && avm_address) && k < 30) begin
      @(posedge clk); #1 k++;
    end
    chk("rst_reached_rd_ts", {30'd0, avm_read, avm_address}, 32'd3);
    #2 mon_en = 1'b0;
    reset_n = 1'b0;
    #1 check_all_zero("rst_async");
    @(posedge clk); #1 reset_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1 if (done) dones++;
    end
    chk("rst_no_done", dones, 0);
    chk("rst_idle", {30'd0, busy, avm_read}, 32'd0);
    mon_en = 1'b1;
    run_vec(vecs[0], "post_rst");

`ifdef SYSID_CHECKER_TIMEOUT_EN
    mon_en = 1'b0;
    stuck = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 1;
    while (!done && k < 30) begin
      @(posedge clk); #1 k++;
    end
    chk("tmo_lat_in_range", {31'd0, (k >= 2 && k <= 10)}, 32'd1);
    chk("tmo_flags", {28'd0, timeout, id_ok, ts_ok, done}, 32'd9);
    chk("tmo_read_off", {30'd0, avm_read, busy}, 32'd0);
    @(posedge clk); #1 chk("tmo_read_after", {31'd0, avm_read}, 32'd0);
    stuck = 1'b0;
    @(posedge clk); #1 mon_en = 1'b1;
    run_vec(vecs[0], "post_tmo");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
